// File: rtl/ppm_tx_pkg.sv
// Shared types and constants for the 4-PPM frame transmitter.
// The state enumeration and symbol geometry live here so both the controller and the slot timer agree.
package ppm_tx_pkg;

  localparam int PPM_SLOTS     = 4;
  localparam int SYM_BITS      = 2;
  localparam int SYMS_PER_BYTE = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SYM      = 3'd2,
    EOF_REQ  = 3'd3,
    EOF_WAIT = 3'd4,
    DONE     = 3'd5
  } ppm_state_e;

  // Symbols are sent MSB-first: index 0 selects bits [7:6].
  function automatic logic [SYM_BITS-1:0] byte_sym(input logic [7:0] b,
                                                   input logic [1:0] idx);
    logic [SYM_BITS-1:0] s;
    case (idx)
      2'd0:    s = b[7:6];
      2'd1:    s = b[5:4];
      2'd2:    s = b[3:2];
      default: s = b[1:0];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ppm_slot_gen.sv
// Slot/cycle timer for one PPM byte: counts cycles within a slot, slots within a symbol
// and symbols within a byte. Held at zero whenever en is low so every byte starts aligned.
module ppm_slot_gen
  import ppm_tx_pkg::*;
#(
  parameter int SLOT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] slot_idx,
  output logic [1:0] sym_idx,
  output logic       slot_end,
  output logic       byte_end
);

  logic [7:0] cyc_cnt;

  assign slot_end = en && (cyc_cnt == 8'(SLOT_CYCLES - 1));
  assign byte_end = slot_end && (slot_idx == 2'(PPM_SLOTS - 1)) &&
                    (sym_idx == 2'(SYMS_PER_BYTE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= 8'd0;
      slot_idx <= 2'd0;
      sym_idx  <= 2'd0;
    end else if (!en) begin
      cyc_cnt  <= 8'd0;
      slot_idx <= 2'd0;
      sym_idx  <= 2'd0;
    end else if (slot_end) begin
      cyc_cnt <= 8'd0;
      if (slot_idx == 2'(PPM_SLOTS - 1)) begin
        slot_idx <= 2'd0;
        sym_idx  <= (sym_idx == 2'(SYMS_PER_BYTE - 1)) ? 2'd0 : sym_idx + 2'd1;
      end else begin
        slot_idx <= slot_idx + 2'd1;
      end
    end else begin
      cyc_cnt <= cyc_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ppm_tx_ctrl.sv
// 4-PPM frame transmitter: pulls tx_len bytes over a valid/ready port, emits each byte as
// four PPM symbols, then hands off to the eof stage and waits (bounded) for its completion.
module ppm_tx_ctrl
  import ppm_tx_pkg::*;
#(
  parameter int SLOT_CYCLES = 1,
  parameter int EOF_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       ppm_out,
  output logic       control_eof,
  input  logic       eof_done,
  output logic       busy,
  output logic       tx_done,
  output logic       underrun,
  output logic       eof_err
);

  // Handshake: a byte transfers on a rising edge where data_valid and data_ready are both
  // high; data_ready is high for exactly the cycles spent in LOAD.

  ppm_state_e  state;
  logic [7:0]  rem_cnt;
  logic [7:0]  byte_q;
  logic [15:0] wait_cnt;
  logic        first_byte;
  logic        load_first;

  logic        sym_en;
  logic [1:0]  slot_idx;
  logic [1:0]  sym_idx;
  logic        slot_end;
  logic        byte_end;

  assign sym_en = (state == SYM);

  ppm_slot_gen #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_slot_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (sym_en),
    .slot_idx (slot_idx),
    .sym_idx  (sym_idx),
    .slot_end (slot_end),
    .byte_end (byte_end)
  );

  assign data_ready  = (state == LOAD);
  assign control_eof = (state == EOF_REQ);
  assign busy        = (state != IDLE);
  assign tx_done     = (state == DONE);
  assign ppm_out     = sym_en && (slot_idx == byte_sym(byte_q, sym_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem_cnt    <= 8'd0;
      byte_q     <= 8'd0;
      wait_cnt   <= 16'd0;
      first_byte <= 1'b0;
      load_first <= 1'b0;
      underrun   <= 1'b0;
      eof_err    <= 1'b0;
    end else begin
      underrun <= 1'b0;
      eof_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            rem_cnt    <= tx_len;
            first_byte <= 1'b1;
            load_first <= 1'b1;
            state      <= (tx_len != 8'd0) ? LOAD : EOF_REQ;
          end
        end
        LOAD: begin
          load_first <= 1'b0;
          // A gap is flagged once, when the byte is not ready on the first LOAD cycle.
          if (load_first && !data_valid && !first_byte) underrun <= 1'b1;
          if (data_valid) begin
            byte_q     <= data_in;
            rem_cnt    <= rem_cnt - 8'd1;
            first_byte <= 1'b0;
            state      <= SYM;
          end
        end
        SYM: begin
          if (slot_end && byte_end) begin
            if (rem_cnt != 8'd0) begin
              load_first <= 1'b1;
              state      <= LOAD;
            end else begin
              state <= EOF_REQ;
            end
          end
        end
        EOF_REQ: begin
          // Counts cycles since control_eof, so the timeout lands EOF_TIMEOUT cycles after it.
          wait_cnt <= 16'd1;
          state    <= EOF_WAIT;
        end
        EOF_WAIT: begin
          if (eof_done) begin
            state <= DONE;
          end else if (wait_cnt >= 16'(EOF_TIMEOUT - 1)) begin
            eof_err <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE: begin
          byte_q   <= 8'd0;
          wait_cnt <= 16'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_tx_ctrl.sv
// Directed bench for ppm_tx_ctrl: hand-computed PPM words per byte, eof handshake timing,
// underrun, timeout, mid-frame reset and ignored-input cases.
module tb_ppm_tx_ctrl;

  localparam int SC       = 1;
  localparam int TO       = 16;
  localparam int BYTE_CYC = 16 * SC;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       tx_start;
  logic [7:0] tx_len;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       ppm_out;
  logic       control_eof;
  logic       eof_done;
  logic       busy;
  logic       tx_done;
  logic       underrun;
  logic       eof_err;

  ppm_tx_ctrl #(
    .SLOT_CYCLES(SC),
    .EOF_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_len      (tx_len),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ppm_out     (ppm_out),
    .control_eof (control_eof),
    .eof_done    (eof_done),
    .busy        (busy),
    .tx_done     (tx_done),
    .underrun    (underrun),
    .eof_err     (eof_err)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  int tot_eof = 0, tot_done = 0, tot_under = 0, tot_err = 0, tot_gap_ppm = 0, tot_idle_ppm = 0;
  int s_eof, s_done, s_under, s_err, s_gap, s_idle;

  always @(negedge clk) begin
    tot_eof      += int'(control_eof);
    tot_done     += int'(tx_done);
    tot_under    += int'(underrun);
    tot_err      += int'(eof_err);
    tot_gap_ppm  += int'(ppm_out && data_ready);
    tot_idle_ppm += int'(ppm_out && !busy);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic snap();
    #1;
    s_eof = tot_eof; s_done = tot_done; s_under = tot_under;
    s_err = tot_err; s_gap = tot_gap_ppm; s_idle = tot_idle_ppm;
  endtask

  function automatic logic [31:0] outs();
    return 32'({data_ready, ppm_out, control_eof, busy, tx_done, underrun, eof_err});
  endfunction

  // driver tasks (all entered and left on a falling edge)
  task automatic start_frame(input logic [7:0] len);
    check("idle_before_start", 32'({busy, control_eof}), 32'd0);
    tx_start = 1'b1;
    tx_len   = len;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_ready();
    int waited;
    waited = 0;
    while (!data_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 32'(data_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    logic [15:0] got;
    logic [15:0] exp_w;
    wait_ready();
    repeat (gap) @(negedge clk);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = 8'd0;
    got = 16'd0;
    for (int k = 0; k < BYTE_CYC; k++) begin
      got[BYTE_CYC-1-k] = ppm_out;
      if (poke && k == 4) begin
        tx_start = 1'b1;
        tx_len   = 8'd0;
        eof_done = 1'b1;
      end
      if (poke && k == 5) begin
        tx_start = 1'b0;
        eof_done = 1'b0;
      end
      @(negedge clk);
    end
    exp_w = exp_q.pop_front();
    check($sformatf("ppm_byte_%02h", b), 32'(got), 32'(exp_w));
  endtask

  // Entered on the falling edge of the control_eof cycle; delay<0 means eof_done never comes.
  task automatic finish_eof(input int delay);
    check("ctrl_eof_on", 32'(control_eof), 32'd1);
    @(negedge clk);
    check("ctrl_eof_one_cycle", 32'(control_eof), 32'd0);
    if (delay >= 1) begin
      repeat (delay - 1) @(negedge clk);
      check("tx_done_early", 32'(tx_done), 32'd0);
      eof_done = 1'b1;
      @(negedge clk);
      eof_done = 1'b0;
      check("tx_done_after_eof", 32'({tx_done, eof_err}), 32'b10);
    end else begin
      repeat (TO - 2) @(negedge clk);
      check("tx_done_before_to", 32'(tx_done), 32'd0);
      @(negedge clk);
      check("timeout_done_err", 32'({tx_done, eof_err}), 32'b11);
    end
    @(negedge clk);
    check("idle_after_done", 32'({busy, tx_done, eof_err}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_len = 8'd0; data_in = 8'd0;
    data_valid = 1'b0; eof_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    tx_start = 1'b1; tx_len = 8'd3; eof_done = 1'b1; data_valid = 1'b1;
    @(negedge clk);
    check("reset_holds_idle", outs(), 32'd0);
    tx_start = 1'b0; eof_done = 1'b0; data_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // single byte 0x1B, eof_done 10 cycles after control_eof
    snap();
    exp_q.push_back(16'h8421);
    start_frame(8'd1);
    send_byte(8'h1B, 0, 1'b0);
    finish_eof(10);
    snap();
    check("f1_eof_count", 32'(tot_eof - s_eof + 1), 32'd1);

    // zero-length frame goes straight to the eof request
    snap();
    start_frame(8'd0);
    finish_eof(3);
    #1;
    check("len0_eof_count", 32'(tot_eof - s_eof), 32'd1);
    check("len0_no_ppm", 32'(tot_idle_ppm - s_idle), 32'd0);

    // three bytes with a 5-cycle gap before byte 2
    snap();
    exp_q.push_back(16'h4422);
    exp_q.push_back(16'h2244);
    exp_q.push_back(16'h8118);
    start_frame(8'd3);
    send_byte(8'h5A, 0, 1'b0);
    send_byte(8'hA5, 5, 1'b0);
    send_byte(8'h3C, 0, 1'b0);
    finish_eof(3);
    #1;
    check("gap_underrun_count", 32'(tot_under - s_under), 32'd1);
    check("gap_ppm_quiet", 32'(tot_gap_ppm - s_gap), 32'd0);

    // eof_done never arrives; first byte late must not count as underrun
    snap();
    exp_q.push_back(16'h1248);
    exp_q.push_back(16'h1111);
    start_frame(8'd2);
    send_byte(8'hE4, 3, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    finish_eof(-1);
    #1;
    check("to_err_count", 32'(tot_err - s_err), 32'd1);
    check("to_no_underrun", 32'(tot_under - s_under), 32'd0);

    // reset in the middle of byte 2 of 4
    snap();
    exp_q.push_back(16'h8888);
    start_frame(8'd4);
    send_byte(8'h00, 0, 1'b0);
    wait_ready();
    data_in = 8'hFF; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sym_pulse_before_rst", 32'(ppm_out), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_mid_outputs", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_abort_no_eof", 32'({tot_eof - s_eof, tot_done - s_done}), 32'd0);
    exp_q.push_back(16'h8118);
    start_frame(8'd1);
    send_byte(8'h3C, 0, 1'b0);
    finish_eof(2);

    // tx_start and eof_done while busy, then eof_done while idle
    snap();
    exp_q.push_back(16'h8888);
    exp_q.push_back(16'h1111);
    start_frame(8'd2);
    tx_start = 1'b1; tx_len = 8'd0; eof_done = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; eof_done = 1'b0;
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b1);
    finish_eof(5);
    #1;
    check("busy_ignore_eof_count", 32'(tot_eof - s_eof), 32'd1);
    snap();
    eof_done = 1'b1;
    @(negedge clk);
    eof_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_eof_done_ignored",
          32'({busy, 8'(tot_eof - s_eof), 8'(tot_done - s_done)}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
